// File: rtl/error_event_logger.sv
// rtl/error_event_logger.sv - error event classifier with saturating counters and a FWFT event log
// One entry per accepted event cycle; irq is registered from next-state flags and occupancy.
module error_event_logger #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ev_single,
  input  logic                          ev_double,
  input  logic                          ev_burst,
  input  logic                          ev_address,
  input  logic                          ev_control,
  input  logic [ADDR_WIDTH-1:0]         ev_addr,
  input  logic                          log_enable,
  input  logic                          clear,
  input  logic [$clog2(FIFO_DEPTH):0]   irq_threshold,
  input  logic                          pop,
  output logic                          log_valid,
  output logic [2:0]                    log_type,
  output logic                          log_multi,
  output logic [ADDR_WIDTH-1:0]         log_addr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          cnt_single,
  output logic [CNT_WIDTH-1:0]          cnt_double,
  output logic [CNT_WIDTH-1:0]          cnt_burst,
  output logic [CNT_WIDTH-1:0]          cnt_address,
  output logic [CNT_WIDTH-1:0]          cnt_control,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          overflow,
  output logic                          irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v, input logic inc);
    return (inc && (v != '1)) ? v + cnt_t'(1) : v;
  endfunction

  logic [2:0]            type_mem_q  [FIFO_DEPTH];
  logic                  multi_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q  [FIFO_DEPTH];

  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [4:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  cnt_t                drop_q, drop_d;
  logic                overflow_q, overflow_d, fatal_q, fatal_d, irq_q, irq_d;

  logic [4:0]          ev_vec;
  logic                ev_cycle, pop_ok, push_ok, drop;
  logic [2:0]          entry_type;
  logic                entry_multi;

  always_comb begin
    // Bit order matches the cnt_q lanes: single, double, burst, address, control.
    ev_vec      = {ev_control, ev_address, ev_burst, ev_double, ev_single};
    ev_cycle    = log_enable && (ev_vec != 5'd0);
    pop_ok      = pop && (count_q != '0);
    push_ok     = ev_cycle && ((count_q != DEPTH_C) || pop_ok);
    drop        = ev_cycle && (count_q == DEPTH_C) && !pop_ok;
    entry_multi = (ev_vec & (ev_vec - 5'd1)) != 5'd0;

    entry_type = 3'd0;
    if (ev_control)      entry_type = 3'd5;
    else if (ev_address) entry_type = 3'd4;
    else if (ev_double)  entry_type = 3'd2;
    else if (ev_burst)   entry_type = 3'd3;
    else if (ev_single)  entry_type = 3'd1;

    wr_ptr_d = wr_ptr_q + (push_ok ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop_ok ? PW'(1) : PW'(0));
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

    // Clear takes effect first so a same-cycle event lands on the zeroed value.
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = sat_inc(clear ? cnt_t'(0) : cnt_q[i], ev_cycle && ev_vec[i]);
    end
    drop_d     = sat_inc(clear ? cnt_t'(0) : drop_q, drop);
    overflow_d = (!clear && overflow_q) || drop;
    fatal_d    = (!clear && fatal_q) || (ev_cycle && (ev_double || ev_address || ev_control));
    irq_d      = fatal_d || overflow_d ||
                 ((irq_threshold != '0) && (count_d >= irq_threshold));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      fatal_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      fatal_q    <= fatal_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      type_mem_q[wr_ptr_q]  <= entry_type;
      multi_mem_q[wr_ptr_q] <= entry_multi;
      addr_mem_q[wr_ptr_q]  <= ev_addr;
    end
  end

  // Head fields are masked so stale storage never leaks out while empty.
  assign log_valid   = count_q != '0;
  assign log_type    = log_valid ? type_mem_q[rd_ptr_q]  : 3'd0;
  assign log_multi   = log_valid ? multi_mem_q[rd_ptr_q] : 1'b0;
  assign log_addr    = log_valid ? addr_mem_q[rd_ptr_q]  : '0;
  assign fifo_count  = count_q;
  assign cnt_single  = cnt_q[0];
  assign cnt_double  = cnt_q[1];
  assign cnt_burst   = cnt_q[2];
  assign cnt_address = cnt_q[3];
  assign cnt_control = cnt_q[4];
  assign drop_count  = drop_q;
  assign overflow    = overflow_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_error_event_logger.sv
// tb/tb_error_event_logger.sv - directed and randomized checks of error_event_logger
// A queue-based reference model predicts every output after each clock edge.
module tb_error_event_logger;
  localparam int AW    = 32;
  localparam int DEPTH = 8;
  localparam int CNTW  = 5;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CNTW) - 1;

  logic clk, rst;
  logic ev_single, ev_double, ev_burst, ev_address, ev_control;
  logic [AW-1:0] ev_addr;
  logic log_enable, clear, pop;
  logic [CW-1:0] irq_threshold;
  logic log_valid, log_multi, overflow, irq;
  logic [2:0] log_type;
  logic [AW-1:0] log_addr;
  logic [CW-1:0] fifo_count;
  logic [CNTW-1:0] cnt_single, cnt_double, cnt_burst, cnt_address, cnt_control, drop_count;

  error_event_logger #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst),
    .ev_single(ev_single), .ev_double(ev_double), .ev_burst(ev_burst),
    .ev_address(ev_address), .ev_control(ev_control), .ev_addr(ev_addr),
    .log_enable(log_enable), .clear(clear), .irq_threshold(irq_threshold), .pop(pop),
    .log_valid(log_valid), .log_type(log_type), .log_multi(log_multi), .log_addr(log_addr),
    .fifo_count(fifo_count),
    .cnt_single(cnt_single), .cnt_double(cnt_double), .cnt_burst(cnt_burst),
    .cnt_address(cnt_address), .cnt_control(cnt_control),
    .drop_count(drop_count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    t;
    logic          m;
    logic [AW-1:0] a;
  } ent_t;

  ent_t q[$];
  int   m_cnt[5];
  int   m_drop;
  bit   m_ov, m_fatal, m_irq;
  int   n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit   s[5];
    int   n;
    ent_t e;
    if (rst) begin
      q.delete();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_drop = 0; m_ov = 0; m_fatal = 0; m_irq = 0;
      return;
    end
    s = '{ev_single, ev_double, ev_burst, ev_address, ev_control};
    n = 0;
    foreach (s[i]) n += s[i];
    if (pop && q.size() > 0) void'(q.pop_front());
    if (clear) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_drop = 0; m_ov = 0; m_fatal = 0;
    end
    if (log_enable && n > 0) begin
      foreach (s[i]) if (s[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      if (s[1] || s[3] || s[4]) m_fatal = 1;
      e.t = s[4] ? 3'd5 : s[3] ? 3'd4 : s[1] ? 3'd2 : s[2] ? 3'd3 : 3'd1;
      e.m = (n > 1);
      e.a = ev_addr;
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        if (m_drop < MAXC) m_drop++;
        m_ov = 1;
      end
    end
    m_irq = m_fatal || m_ov || (irq_threshold != 0 && q.size() >= irq_threshold);
  endtask

  task automatic compare_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("log_valid", log_valid, q.size() != 0);
    chk("log_type", log_type, h.t);
    chk("log_multi", log_multi, h.m);
    chk("log_addr", log_addr, h.a);
    chk("fifo_count", fifo_count, q.size());
    chk("cnt_single", cnt_single, m_cnt[0]);
    chk("cnt_double", cnt_double, m_cnt[1]);
    chk("cnt_burst", cnt_burst, m_cnt[2]);
    chk("cnt_address", cnt_address, m_cnt[3]);
    chk("cnt_control", cnt_control, m_cnt[4]);
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ov);
    chk("irq", irq, m_irq);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // ev bits: 0 single, 1 double, 2 burst, 3 address, 4 control
  task automatic step(input logic [4:0] ev, input logic [AW-1:0] addr, input bit p);
    {ev_control, ev_address, ev_burst, ev_double, ev_single} = ev;
    ev_addr = addr;
    pop = p;
    cycle();
    {ev_control, ev_address, ev_burst, ev_double, ev_single} = 5'd0;
    ev_addr = '0;
    pop = 0;
    clear = 0;
  endtask

  initial begin
    clk = 0; rst = 1;
    {ev_control, ev_address, ev_burst, ev_double, ev_single} = 5'd0;
    ev_addr = '0; log_enable = 0; clear = 0; pop = 0; irq_threshold = '0;
    cycle();
    chk("rst_valid", log_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_irq", irq, 0);
    cycle();
    rst = 0;
    log_enable = 1;

    step(5'b00001, 32'h100, 0);
    chk("single_valid", log_valid, 1);
    chk("single_type", log_type, 1);
    chk("single_multi", log_multi, 0);
    chk("single_addr", log_addr, 32'h100);
    chk("single_cnt", cnt_single, 1);
    chk("single_irq", irq, 0);
    step(5'b00000, 0, 1);

    step(5'b10100, 32'h200, 0);
    chk("multi_type", log_type, 5);
    chk("multi_flag", log_multi, 1);
    chk("multi_cnt_burst", cnt_burst, 1);
    chk("multi_cnt_control", cnt_control, 1);
    chk("multi_irq", irq, 1);
    clear = 1;
    step(5'b00000, 0, 0);
    chk("clear_cnt_burst", cnt_burst, 0);
    chk("clear_cnt_control", cnt_control, 0);
    chk("clear_irq", irq, 0);
    chk("clear_keeps_fifo", fifo_count, 1);
    step(5'b00000, 0, 1);

    for (int i = 0; i < 10; i++) step(5'b00001, 32'h1000 + i, 0);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_irq", irq, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", log_addr, 32'h1000 + i);
      step(5'b00000, 0, 1);
    end
    chk("ovf_drained", fifo_count, 0);

    for (int i = 0; i < 8; i++) step(5'b00001, 32'h2000 + i, 0);
    step(5'b00001, 32'h3000, 1);
    chk("full_pp_count", fifo_count, 8);
    chk("full_pp_drop", drop_count, 2);
    chk("full_pp_head", log_addr, 32'h2001);
    for (int i = 0; i < 7; i++) step(5'b00000, 0, 1);
    chk("full_pp_last", log_addr, 32'h3000);
    chk("full_pp_one", fifo_count, 1);
    step(5'b00000, 0, 1);

    clear = 1;
    step(5'b00000, 0, 0);
    irq_threshold = 3;
    step(5'b00001, 32'h10, 0);
    step(5'b00001, 32'h14, 0);
    chk("thr_below", irq, 0);
    step(5'b00001, 32'h18, 0);
    chk("thr_hit_irq", irq, 1);
    chk("thr_hit_count", fifo_count, 3);
    step(5'b00000, 0, 1);
    chk("thr_fall_irq", irq, 0);
    step(5'b00000, 0, 1);
    step(5'b00000, 0, 1);
    irq_threshold = 0;

    log_enable = 0;
    step(5'b11111, 32'h55, 0);
    chk("disabled_cnt", cnt_single, 3);
    chk("disabled_count", fifo_count, 0);
    chk("disabled_irq", irq, 0);
    log_enable = 1;

    for (int i = 0; i < 4; i++) step(5'b00001, 32'h40 + i, 0);
    #3 rst = 1;
    #1;
    chk("arst_valid", log_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_addr", log_addr, 0);
    chk("arst_type", log_type, 0);
    chk("arst_cnt", cnt_single, 0);
    chk("arst_irq", irq, 0);
    cycle();
    rst = 0;
    step(5'b00001, 32'hABC, 0);
    chk("post_rst_head", log_addr, 32'hABC);
    chk("post_rst_count", fifo_count, 1);
    step(5'b00000, 0, 1);

    for (int i = 0; i < 40; i++) step(5'b00001, 32'h500 + i, 0);
    chk("sat_cnt", cnt_single, MAXC);
    chk("sat_drop", drop_count, MAXC);
    clear = 1;
    step(5'b00000, 0, 0);
    for (int i = 0; i < 8; i++) step(5'b00000, 0, 1);

    for (int k = 0; k < 600; k++) begin
      ev_single  = $urandom_range(0, 9) < 3;
      ev_double  = $urandom_range(0, 9) < 1;
      ev_burst   = $urandom_range(0, 9) < 2;
      ev_address = $urandom_range(0, 19) < 1;
      ev_control = $urandom_range(0, 29) < 1;
      ev_addr    = $urandom();
      log_enable = $urandom_range(0, 9) != 0;
      pop        = $urandom_range(0, 9) < ((k % 200) < 100 ? 3 : 8);
      clear      = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 19) == 0) irq_threshold = CW'($urandom_range(0, 8));
      rst        = $urandom_range(0, 199) == 0;
      cycle();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/error_event_logger.md
ERROR_EVENT_LOGGER -- requirements
Module: error_event_logger

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of logged address.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, log entries; power of two, at least 2.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of every counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports ev_single, ev_double, ev_burst, ev_address, ev_control  input  1 each  one-cycle event strobes from the error injector.
REQ-007 SHALL have port ev_addr  input  ADDR_WIDTH  address associated with any strobe this cycle.
REQ-008 SHALL have ports log_enable  input  1  (event capture enable) and clear  input  1  (clears counters/flags, not FIFO).
REQ-009 SHALL have port irq_threshold  input  $clog2(FIFO_DEPTH)+1  FIFO-occupancy interrupt level; 0 disables.
REQ-010 SHALL have port pop  input  1  consumer removes head entry.
REQ-011 SHALL have ports log_valid  output  1, log_type  output  3, log_multi  output  1, log_addr  output  ADDR_WIDTH  FIFO head.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-013 SHALL have ports cnt_single, cnt_double, cnt_burst, cnt_address, cnt_control  output  CNT_WIDTH each  per-type event counts.
REQ-014 SHALL have ports drop_count  output  CNT_WIDTH, overflow  output  1, irq  output  1.

Function
REQ-015 SHALL treat a cycle as an event cycle when log_enable=1 and at least one ev_* is 1; with log_enable=0 all strobes are ignored (no push, no count).
REQ-016 SHALL form one entry per event cycle: type = highest-priority asserted strobe (control=5 > address=4 > double=2 > burst=3 > single=1), multi = 1 if more than one strobe is asserted, addr = ev_addr.
REQ-017 SHALL implement the FIFO as first-word-fall-through: log_valid = (fifo_count != 0); log_type/log_multi/log_addr show the oldest entry; when log_valid=0 they read 0.
REQ-018 SHALL treat pop with log_valid=0 as a no-op.
REQ-019 SHALL make an entry pushed at edge N visible on log_valid/fifo_count from edge N+1 (one-cycle latency).
REQ-020 SHALL, on simultaneous push and pop, keep fifo_count unchanged, including when full (push accepted).
REQ-021 SHALL, on push while full without pop, drop the entry, increment drop_count (saturating) and set overflow (sticky).
REQ-022 SHALL increment each cnt_* by 1 per cycle its strobe is accepted under REQ-015, independent of priority or FIFO drop; all counters saturate at all-ones.
REQ-023 SHALL, on clear=1, zero all cnt_*, drop_count, overflow and the sticky fatal flag; an event in the same cycle is applied after the clear (counter reads 1).
REQ-024 SHALL set a sticky fatal flag when an accepted event includes ev_double, ev_address or ev_control.
REQ-025 SHALL drive irq as a register equal to fatal OR overflow OR (irq_threshold != 0 AND fifo_count >= irq_threshold), all evaluated on next-state values, so irq rises on the same edge as the causing update.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH with no gaps or reordering.

Reset
REQ-027 SHALL, while rst=1, force fifo_count=0, log_valid=0, log_type=0, log_multi=0, log_addr=0, all cnt_*=0, drop_count=0, overflow=0, fatal=0, irq=0, asynchronously.
REQ-028 SHALL discard FIFO contents on reset asserted mid-operation; the first accepted event after rst falls is stored at the FIFO head.

Verification
REQ-029 SHALL verify: log_enable=1, ev_single with ev_addr=0x100 -> next cycle log_valid=1, log_type=1, log_multi=0, log_addr=0x100, cnt_single=1, irq=0.
REQ-030 SHALL verify: ev_burst+ev_control same cycle, addr 0x200 -> one entry type=5, multi=1; cnt_burst=1, cnt_control=1, irq=1; clear -> counters 0, irq=0 (FIFO entry retained).
REQ-031 SHALL verify: DEPTH=8, 10 single events without pop -> fifo_count=8, drop_count=2, overflow=1, irq=1; 8 pops return addresses in order.
REQ-032 SHALL verify: FIFO full, push and pop same cycle -> fifo_count stays 8, drop_count unchanged, new entry appears last.
REQ-033 SHALL verify: irq_threshold=3, three single events -> irq rises with fifo_count=3; one pop -> irq falls next edge.
REQ-034 SHALL verify: log_enable=0 with strobes -> no change; rst pulse with 4 entries -> fifo_count=0, all outputs 0 immediately.
